// File: rtl/fifo_ctrl_if.sv
// Request/strobe/flag bundle between producer-consumer logic and the FIFO pointer controller.
interface fifo_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              wr_req;
  logic              rd_req;
  logic              flush;
  logic              err_clr;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] b_wrptr;
  logic [ADDR_W-1:0] b_rdptr;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              rd_valid;
  logic              ovf;
  logic              udf;

  modport master (
    output wr_req, rd_req, flush, err_clr,
    input  wr_en, rd_en, b_wrptr, b_rdptr, full, empty, almost_full, almost_empty,
    input  count, rd_valid, ovf, udf
  );

  modport slave (
    input  wr_req, rd_req, flush, err_clr,
    output wr_en, rd_en, b_wrptr, b_rdptr, full, empty, almost_full, almost_empty,
    output count, rd_valid, ovf, udf
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 16x8 FIFO memory; strobes are combinational, flags registered, read data valid 1 clk later.
// Requests against a full/empty FIFO are dropped (no retry) and latched into sticky ovf/udf.
module fifo_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic       clk,
  input logic       rst_n,
  fifo_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] AF_TH = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_TH = AE_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wptr, rptr, wptr_nxt, rptr_nxt, cnt_nxt, cnt_q;
  logic            full_q, empty_q, af_q, ae_q, rdv_q, ovf_q, udf_q;
  logic            wr_acc, rd_acc, wr_rej, rd_rej;

  always_comb begin
    wr_acc = bus.wr_req & ~full_q  & ~bus.flush;
    rd_acc = bus.rd_req & ~empty_q & ~bus.flush;
    wr_rej = bus.wr_req &  full_q  & ~bus.flush;
    rd_rej = bus.rd_req &  empty_q & ~bus.flush;
  end

  // Flags are computed from the next pointer values so they land on the same edge as the pointers.
  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (bus.flush) begin
      wptr_nxt = '0;
      rptr_nxt = '0;
    end else begin
      if (wr_acc) wptr_nxt = wptr + ONE;
      if (rd_acc) rptr_nxt = rptr + ONE;
    end
    cnt_nxt = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      rdv_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      cnt_q   <= cnt_nxt;
      full_q  <= (wptr_nxt[ADDR_W] != rptr_nxt[ADDR_W]) &&
                 (wptr_nxt[ADDR_W-1:0] == rptr_nxt[ADDR_W-1:0]);
      empty_q <= (wptr_nxt == rptr_nxt);
      af_q    <= (cnt_nxt >= AF_TH);
      ae_q    <= (cnt_nxt <= AE_TH);
      rdv_q   <= rd_acc;
      // A new error in the same cycle as err_clr wins.
      ovf_q   <= wr_rej | (ovf_q & ~bus.err_clr);
      udf_q   <= rd_rej | (udf_q & ~bus.err_clr);
    end
  end

  assign bus.wr_en        = wr_acc;
  assign bus.rd_en        = rd_acc;
  assign bus.b_wrptr      = wptr[ADDR_W-1:0];
  assign bus.b_rdptr      = rptr[ADDR_W-1:0];
  assign bus.count        = cnt_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_valid     = rdv_q;
  assign bus.ovf          = ovf_q;
  assign bus.udf          = udf_q;

endmodule
